// File: rtl/serial_byte_framer_pkg.sv
// ----------------------------------------------------------------------------
// serial_framer_pkg
//
// Shared types and constants for the serial byte framer.
//   framer_state_t : framer state machine encoding (WARMUP, HUNT, LOCKED)
//   fifo_entry_t   : one output FIFO entry (start-of-frame flag + data byte)
//   WARMUP_CYCLES  : cycles spent ignoring the deserializer after reset
// ----------------------------------------------------------------------------
package serial_framer_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } framer_state_t;

    typedef struct packed {
        logic       sof;
        logic [7:0] data;
    } fifo_entry_t;

    // The deserializer needs eight shifts before its window holds only
    // freshly received bits instead of its reset pattern.
    localparam int WARMUP_CYCLES = 8;

endpackage

// File: rtl/serial_byte_framer_if.sv
// ----------------------------------------------------------------------------
// serial_byte_framer_if
//
// Valid/ready byte stream from the framer to its consumer.
//   BYTE_OUT   : head byte of the framer output FIFO
//   BYTE_SOF   : head byte is the first data byte of a frame
//   BYTE_VALID : a byte is available
//   BYTE_READY : consumer takes the head byte when BYTE_VALID is high
// Modports: master = framer side, slave = consumer side.
// ----------------------------------------------------------------------------
interface serial_byte_framer_if;

    logic [7:0] BYTE_OUT;
    logic       BYTE_SOF;
    logic       BYTE_VALID;
    logic       BYTE_READY;

    modport master (
        output BYTE_OUT,
        output BYTE_SOF,
        output BYTE_VALID,
        input  BYTE_READY
    );

    modport slave (
        input  BYTE_OUT,
        input  BYTE_SOF,
        input  BYTE_VALID,
        output BYTE_READY
    );

endinterface

// File: rtl/serial_byte_framer_byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
//
// Show-ahead FIFO of fifo_entry_t used as the framer output buffer.
//   CLK, nRST      : clock, asynchronous active-low reset
//   push           : request to store push_entry
//   push_entry     : entry to store
//   pop            : consumer ready; only acts while the FIFO is non-empty
//   head           : current head entry (all zero while empty)
//   valid          : FIFO non-empty
//   level          : number of stored entries
//   overflow_pulse : a push was dropped this cycle because the FIFO was full
// ----------------------------------------------------------------------------
module byte_fifo
    import serial_framer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              push,
    input  fifo_entry_t       push_entry,
    input  logic              pop,
    output fifo_entry_t       head,
    output logic              valid,
    output logic [LVL_W-1:0]  level,
    output logic              overflow_pulse
);

    fifo_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign valid = !empty;

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // accept a push when the consumer is taking a byte at the same time.
    assign do_pop         = pop && !empty;
    assign do_push        = push && (!full || do_pop);
    assign overflow_pulse = push && full && !do_pop;

    // Gate the head so the outputs read zero while nothing is stored.
    assign head = valid ? mem[rd_ptr] : '0;

    // Storage array; contents are only meaningful between the pointers, so
    // it needs no reset.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because the depth is a power of two; the level
    // counter tracks occupancy so full and empty never become ambiguous.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/serial_byte_framer.sv
// ----------------------------------------------------------------------------
// serial_byte_framer
//
// Watches the parallel window of an LSB-first right-shift deserializer,
// hunts for SYNC_BYTE, then samples every eighth window as a byte. The sync
// position of each frame is checked and MISS_LIMIT consecutive misses drop
// lock. Data bytes are queued in a small FIFO towards the consumer.
//   CLK, nRST  : clock, asynchronous active-low reset
//   SR_WINDOW  : deserializer register, newest bit in [7]
//   byte_if    : valid/ready output stream (master side)
//   LOCKED     : framer is locked to the frame structure
//   OVERFLOW   : sticky, a data byte was dropped because the FIFO was full
//   CLR_OVF    : synchronous clear of OVERFLOW (a new drop wins)
//   FIFO_LEVEL : number of queued bytes
// ----------------------------------------------------------------------------
module serial_byte_framer
    import serial_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         FRAME_LEN  = 16,
    parameter int         MISS_LIMIT = 2,
    parameter int         FIFO_DEPTH = 4,
    localparam int        LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [7:0]           SR_WINDOW,
    serial_byte_framer_if.master byte_if,
    output logic                 LOCKED,
    output logic                 OVERFLOW,
    input  logic                 CLR_OVF,
    output logic [LVL_W-1:0]     FIFO_LEVEL
);

    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int WARM_W = $clog2(WARMUP_CYCLES);

    framer_state_t     state;
    framer_state_t     state_next;
    logic [WARM_W-1:0] warm_cnt;
    logic [2:0]        bit_cnt;
    logic [IDX_W-1:0]  byte_idx;
    logic [MISS_W-1:0] miss_cnt;
    logic [MISS_W-1:0] miss_inc;

    logic              sync_match;
    logic              warm_done;
    logic              capture;
    logic              at_sync;
    logic              idx_last;
    logic              lose_lock;

    logic              push;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic              fifo_valid;
    logic              ovf_pulse;

    assign sync_match = (SR_WINDOW == SYNC_BYTE);
    assign warm_done  = (warm_cnt == WARM_W'(WARMUP_CYCLES - 1));
    assign capture    = (state == serial_framer_pkg::LOCKED) && (bit_cnt == 3'd7);
    assign at_sync    = (byte_idx == '0);
    assign idx_last   = (byte_idx == IDX_W'(FRAME_LEN - 1));
    assign miss_inc   = miss_cnt + 1'b1;

    // Lock is lost on the sync-position capture whose miss brings the
    // running miss count up to the limit.
    assign lose_lock  = capture && at_sync && !sync_match &&
                        (miss_inc == MISS_W'(MISS_LIMIT));

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= serial_framer_pkg::WARMUP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: wait out the deserializer reset pattern, hunt for
    // the sync byte, then stay locked until too many syncs are missed.
    always_comb begin
        state_next = state;
        case (state)
            serial_framer_pkg::WARMUP: begin
                if (warm_done) begin
                    state_next = serial_framer_pkg::HUNT;
                end
            end
            serial_framer_pkg::HUNT: begin
                if (sync_match) begin
                    state_next = serial_framer_pkg::LOCKED;
                end
            end
            serial_framer_pkg::LOCKED: begin
                if (lose_lock) begin
                    state_next = serial_framer_pkg::HUNT;
                end
            end
            default: state_next = serial_framer_pkg::WARMUP;
        endcase
    end

    // Position counters. On a sync match the sync byte itself counts as
    // byte 0, so the next captured byte is index 1 and bit counting starts
    // from zero on the following cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            warm_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                serial_framer_pkg::WARMUP: begin
                    warm_cnt <= warm_cnt + 1'b1;
                end
                serial_framer_pkg::HUNT: begin
                    if (sync_match) begin
                        bit_cnt  <= '0;
                        byte_idx <= IDX_W'(1);
                        miss_cnt <= '0;
                    end
                end
                serial_framer_pkg::LOCKED: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (capture) begin
                        byte_idx <= idx_last ? '0 : byte_idx + 1'b1;
                        if (at_sync) begin
                            miss_cnt <= sync_match ? '0 : miss_inc;
                        end
                    end
                end
                default: begin
                    warm_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs of the state machine: lock indication and the FIFO push for
    // every captured byte that is not in the sync position.
    always_comb begin
        LOCKED     = (state == serial_framer_pkg::LOCKED);
        push       = 1'b0;
        push_entry = '0;
        if (capture && !at_sync) begin
            push            = 1'b1;
            push_entry.sof  = (byte_idx == IDX_W'(1));
            push_entry.data = SR_WINDOW;
        end
    end

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK            (CLK),
        .nRST           (nRST),
        .push           (push),
        .push_entry     (push_entry),
        .pop            (byte_if.BYTE_READY),
        .head           (head),
        .valid          (fifo_valid),
        .level          (FIFO_LEVEL),
        .overflow_pulse (ovf_pulse)
    );

    assign byte_if.BYTE_OUT   = head.data;
    assign byte_if.BYTE_SOF   = head.sof;
    assign byte_if.BYTE_VALID = fifo_valid;

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            OVERFLOW <= 1'b0;
        end else if (ovf_pulse) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_OVF) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: doc/serial_byte_framer.md
# serial_byte_framer

Byte framer sitting directly downstream of the 8-bit right-shift deserializer. It watches the deserializer's parallel window each cycle, hunts for a sync byte, and then captures every eighth window as a byte. It tracks frame position and drops out of lock on repeated sync misses. Captured data bytes go through a small FIFO with a valid/ready interface to the consumer.

## Interface
- SYNC_BYTE, 8'hA5: frame sync pattern. Must not equal 8'h55, the deserializer's reset value.
- FRAME_LEN, 16: bytes per frame, including the sync byte (range 2..256).
- MISS_LIMIT, 2: consecutive sync mismatches that cause loss of lock (≥1).
- FIFO_DEPTH, 4: output FIFO entries (power of 2, ≥2).

Ports:
- CLK, in, 1: clock.
- nRST, in, 1: asynchronous, active-low reset.
- SR_WINDOW, in, 8: deserializer register. Newest bit is in [7]; one new bit arrives per CLK. LSB-first bytes are complete when aligned.
- BYTE_OUT, out, 8: FIFO head byte.
- BYTE_SOF, out, 1: FIFO head is the first data byte of a frame.
- BYTE_VALID, out, 1: FIFO non-empty.
- BYTE_READY, in, 1: consumer accepts the head byte when BYTE_VALID is also high.
- LOCKED, out, 1: framer is in LOCKED state.
- OVERFLOW, out, 1: sticky flag; a data byte was dropped because the FIFO was full.
- CLR_OVF, in, 1: synchronous clear of OVERFLOW.
- FIFO_LEVEL, out, $clog2(FIFO_DEPTH)+1: number of stored entries.

## Operation
- States: WARMUP, HUNT, LOCKED. These are the only states.
- WARMUP
  - Entered on reset.
  - Counts 8 cycles. SR_WINDOW is ignored because it still holds the reset pattern.
  - Goes to HUNT after the 8th cycle.
- HUNT
  - Compares SR_WINDOW with SYNC_BYTE every cycle.
  - On a match: go to LOCKED, set bit_cnt=0, byte_idx=1, miss_cnt=0.
- LOCKED
  - bit_cnt increments every cycle, modulo 8.
  - When bit_cnt==7, SR_WINDOW is captured as byte byte_idx, and byte_idx advances modulo FRAME_LEN.
- Capture at byte_idx==0 (sync position):
  - Match: miss_cnt=0. Nothing is pushed.
  - Mismatch: miss_cnt+1. If the new value equals MISS_LIMIT, go to HUNT. Nothing is pushed in either case.
- Capture at byte_idx 1..FRAME_LEN-1: push {sof=(byte_idx==1), byte} into the FIFO.
- FIFO behaviour:
  - Show-ahead: the head is visible on BYTE_OUT and BYTE_SOF.
  - Pop on BYTE_VALID & BYTE_READY.
  - Full with push and pop in the same cycle: both succeed, level unchanged, no overflow.
  - Full with push and no pop: byte dropped, OVERFLOW set.
- OVERFLOW:
  - Cleared by CLR_OVF.
  - If a set and CLR_OVF occur in the same cycle, the set wins.
- Loss of lock does not flush the FIFO. Bytes already queued still drain.
- BYTE_READY while BYTE_VALID is low has no effect.

## Timing
- Reset values (asynchronous):
  - Outputs: BYTE_OUT=0, BYTE_SOF=0, BYTE_VALID=0, LOCKED=0, OVERFLOW=0, FIFO_LEVEL=0.
  - State=WARMUP. All counters 0. FIFO pointers 0.
- Reset mid-frame: everything clears immediately. Queued bytes are lost. WARMUP restarts on the first CLK edge after nRST rises.
- Acquisition timing, with the sync match in HUNT at cycle t:
  - LOCKED=1 at t+1.
  - First data window is captured at t+8.
  - BYTE_VALID=1 at t+9 if the FIFO was empty.
- Capture latency: a byte captured at cycle c is visible on BYTE_OUT at c+1.
- Pop latency: a pop at cycle p presents the next entry, or deasserts BYTE_VALID, at p+1.
- Loss of lock: LOCKED falls the cycle after the failing sync capture. HUNT may re-match on that same cycle's SR_WINDOW.
- FIFO_LEVEL updates one cycle after push or pop. Pointers wrap modulo FIFO_DEPTH.

## Structure
- Package serial_framer_pkg:
  - typedef enum framer_state_t {WARMUP, HUNT, LOCKED}.
  - typedef struct fifo_entry_t {sof, data[7:0]}.
  - localparam WARMUP_CYCLES=8.
- Sub-module byte_fifo:
  - Parameterised by FIFO_DEPTH, stores fifo_entry_t.
  - Contains push/pop logic, full/empty detection, level output and the overflow pulse.
- The top level holds the state machine, bit_cnt, byte_idx and miss_cnt.

## Test plan
- Reset, then SR_WINDOW held at 8'h55 and 8'hA5 presented during warm-up cycles 0–7 → LOCKED stays 0, BYTE_VALID stays 0, all outputs keep their reset values.
- Serial stream of A5 followed by 01..0F (LSB-first, through the deserializer), BYTE_READY=1 → LOCKED=1 at t+1, 15 bytes 01..0F out in order, BYTE_SOF only on 01, first BYTE_VALID at t+9.
- Same stream with BYTE_READY=0 → FIFO holds 01..04 and FIFO_LEVEL=4. OVERFLOW rises on byte 05 and remains set. A CLR_OVF pulse then clears it. Raising BYTE_READY drains 01..04.
- FIFO full with a push and a pop in the same cycle → no overflow, level stays 4, output order preserved.
- MISS_LIMIT=2, one corrupted sync byte (5A) followed by a good one → stays LOCKED, data continues. Two consecutive corrupted syncs → LOCKED falls the cycle after the second, and queued bytes still drain.
- nRST asserted mid-frame with 3 bytes queued → all outputs reset immediately. Re-acquisition needs 8 warm-up cycles plus a fresh sync.
